rolled_mult_seq: RTL and testbench
==================================

Name: rolled_mult_seq

Overview:
- Sequencer for a rolled-up shift-and-add multiplier.
- Replaces a WIDTH-stage unrolled multiplier with one adder, a left-shifting multiplicand register and a right-shifting multiplier register, iterated over WIDTH clocks.
- A small FSM sits in front of the shared datapath. It accepts one operand pair at a time over a valid/ready handshake and returns the product over a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand width in bits. Legal range is WIDTH >= 2. The product is 2*WIDTH bits.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_arst_n  input  1  asynchronous, active-low reset.
- i_a  input  WIDTH  multiplicand, unsigned.
- i_b  input  WIDTH  multiplier, unsigned.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  block can accept an operand pair.
- o_product  output  2*WIDTH  product, unsigned.
- o_valid  output  1  o_product valid.
- i_ready  input  1  downstream accepts the product.
- o_busy  output  1  high while in RUN.

Behaviour:
- Reset: the asynchronous assertion of i_arst_n forces the following immediately, regardless of any operation in progress:
  - state = IDLE;
  - multiplicand register (2*WIDTH bits), multiplier register (WIDTH bits), accumulator (2*WIDTH bits) and iteration counter ($clog2(WIDTH+1) bits) = 0;
  - o_valid = 0, o_busy = 0, o_product = 0, o_ready = 1.
  - An operation interrupted by reset is discarded; no partial result is presented.
- Release of reset is synchronous to i_clk. It is taken on the first rising edge after i_arst_n goes high.
- State-decoded outputs:
  - o_ready = (state == IDLE).
  - o_busy = (state == RUN).
  - o_valid = (state == DONE).
  - o_product is driven directly from the accumulator.
- IDLE: on an edge with i_valid = 1:
  - multiplicand register <= zero-extended i_a;
  - multiplier register <= i_b;
  - accumulator <= 0;
  - counter <= 0;
  - go to RUN.
  - With i_valid = 0, hold all state. The accumulator keeps the last product.
- RUN: on each edge:
  - if the multiplier register LSB is 1, accumulator <= accumulator + multiplicand register (2*WIDTH-bit add, cannot overflow);
  - multiplicand register <= multiplicand register << 1, zero fill;
  - multiplier register <= multiplier register >> 1, zero fill;
  - counter <= counter + 1.
  - When counter == WIDTH-1 on this edge, go to DONE.
  - RUN therefore lasts exactly WIDTH cycles.
- DONE: hold all state.
  - On an edge with i_ready = 1, go to IDLE. The product is consumed.
  - With i_ready = 0, remain in DONE indefinitely. o_product stays stable.
- Latency: if the operand pair is accepted on edge E, o_valid is high from edge E+WIDTH onward.
- Minimum issue interval is WIDTH+2 cycles:
  - o_ready is low in DONE, so a new pair is never accepted on the same edge a product is consumed;
  - the earliest next acceptance is the edge after returning to IDLE.
- i_valid while in RUN or DONE is ignored; the operands are not captured. Upstream must hold i_valid and the operands until o_ready = 1.
- i_ready outside DONE is ignored.
- Operands are sampled only on the acceptance edge. Changes to i_a/i_b during RUN have no effect.
- Boundary cases:
  - i_b = 0 gives product 0 after the full WIDTH cycles.
  - i_a = i_b = 2^WIDTH-1 gives (2^WIDTH-1)^2 with no truncation.

Optional Feature:
- Macro: ROLLMUL_EARLY_TERM_EN.
- Defined: RUN also exits to DONE on an edge where the multiplier register value after the shift is zero, i.e. no remaining set bits.
  - RUN lasts 1 + (index of the highest set bit of i_b) cycles, minimum 1 cycle (including i_b = 0), maximum WIDTH.
  - Latency is variable; the product value is identical to the non-early-terminated result.
- Undefined: fixed WIDTH-cycle RUN as described above; the early-exit logic is absent.

Test Plan:
- Reset and idle: assert i_arst_n low mid-simulation, then release -> o_ready = 1, o_valid = 0, o_busy = 0, o_product = 0; outputs change asynchronously on assertion.
- Single multiply, WIDTH = 8: i_a = 13, i_b = 11 accepted on edge E -> o_busy high for 8 cycles; o_valid = 1 from E+8; o_product = 0x008F; returns to IDLE on i_ready.
- Extremes: i_a = 255, i_b = 255 -> 0xFE01; i_a = 0, i_b = 200 -> 0x0000; i_a = 200, i_b = 0 -> 0x0000 after 8 RUN cycles.
- Back-pressure and ignored inputs:
  - hold i_ready = 0 for 5 cycles in DONE -> o_product is stable and o_valid stays 1;
  - i_valid pulses with new operands during RUN/DONE are not captured;
  - after i_ready, the next accepted pair produces its own correct product.
- Reset mid-operation: assert i_arst_n low on the 4th RUN cycle of 100*3, then release -> IDLE with o_product = 0 and no o_valid; a following 7*9 gives 0x003F.
- ROLLMUL_EARLY_TERM_EN defined:
  - i_b = 1, i_a = 77 -> RUN 1 cycle, o_product = 77;
  - i_b = 0x10 -> RUN 5 cycles;
  - i_b = 0x80 -> RUN 8 cycles;
  - all products match the reference multiply.

Source files
------------

// File: rtl/rolled_mult_seq.sv
// Rolled shift-and-add multiplier: one adder iterated WIDTH clocks behind a valid/ready front end.
// Optional macro ROLLMUL_EARLY_TERM_EN lets RUN exit once the multiplier register has no set bits left.
//
// state | meaning
// IDLE  | waiting for an operand pair; o_ready high, accumulator holds last product
// RUN   | one shift-and-add iteration per clock; o_busy high
// DONE  | product presented on o_product with o_valid high until i_ready
module rolled_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic               i_clk,
   input  logic               i_arst_n,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   input  logic               i_valid,
   output logic               o_ready,
   output logic [2*WIDTH-1:0] o_product,
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;

   logic [WIDTH-1:0]   mplier_shift;
   logic [2*WIDTH-1:0] acc_sum;
   logic               run_last;

   assign mplier_shift = mplier >> 1;
   assign acc_sum      = acc + mcand;

`ifdef ROLLMUL_EARLY_TERM_EN
   // Once no set bits remain, further iterations cannot change the accumulator.
   assign run_last = (cnt == CNT_LAST) || (mplier_shift == '0);
`else
   assign run_last = (cnt == CNT_LAST);
`endif

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  mcand  <= {{WIDTH{1'b0}}, i_a};
                  mplier <= i_b;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (mplier[0]) begin
                  acc <= acc_sum;
               end
               mcand  <= mcand << 1;
               mplier <= mplier_shift;
               cnt    <= cnt + 1'b1;
               if (run_last) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // ready is low here, so a new pair can only be taken one edge later
               if (i_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign o_ready   = (state == IDLE);
   assign o_busy    = (state == RUN);
   assign o_valid   = (state == DONE);
   assign o_product = acc;

endmodule

// File: tb/tb_rolled_mult_seq.sv
// Directed table-driven bench for rolled_mult_seq (WIDTH = 8), plus reset and back-pressure sequences.
module tb_rolled_mult_seq;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] prod;
      int             hold;
   } vec_t;

   logic           clk;
   logic           arst_n;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           in_valid;
   logic           rdy;
   logic [2*W-1:0] product;
   logic           out_valid;
   logic           ds_ready;
   logic           busy;

   int n_checks = 0;
   int n_fail   = 0;

   rolled_mult_seq #(.WIDTH(W)) dut (
      .i_clk     (clk),
      .i_arst_n  (arst_n),
      .i_a       (a),
      .i_b       (b),
      .i_valid   (in_valid),
      .o_ready   (rdy),
      .o_product (product),
      .o_valid   (out_valid),
      .i_ready   (ds_ready),
      .o_busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int exp_run(input logic [W-1:0] bv);
      int r;
`ifdef ROLLMUL_EARLY_TERM_EN
      r = 1;
      for (int i = 0; i < W; i++) if (bv[i]) r = i + 1;
`else
      r = W;
`endif
      return r;
   endfunction

   // Issue one pair, disturb inputs during RUN/DONE, check product, hold, then consume.
   task automatic run_vec(input vec_t v);
      int n_busy;
      bit got;
      logic [2*W-1:0] held;
      @(negedge clk);
      chk("ready_before_issue", 32'(rdy), 32'd1);
      a = v.a;
      b = v.b;
      in_valid = 1'b1;
      @(negedge clk);
      a = ~v.a;
      b = ~v.b;
      n_busy = 0;
      got = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) begin
            got = 1;
            break;
         end
         if (busy) n_busy++;
         @(negedge clk);
      end
      if (!got) chk("valid_timeout", 32'(out_valid), 32'd1);
      chk("run_cycles", 32'(n_busy), 32'(exp_run(v.b)));
      chk("product", 32'(product), 32'(v.prod));
      chk("busy_in_done", 32'(busy), 32'd0);
      held = product;
      repeat (v.hold) @(negedge clk);
      in_valid = 1'b0;
      chk("product_held", 32'(product), 32'(held));
      chk("valid_held", 32'(out_valid), 32'd1);
      ds_ready = 1'b1;
      @(negedge clk);
      ds_ready = 1'b0;
      chk("valid_after_consume", 32'(out_valid), 32'd0);
      chk("ready_after_consume", 32'(rdy), 32'd1);
      @(negedge clk);
      chk("idle_keeps_product", 32'(product), 32'(v.prod));
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{a: 8'd13,  b: 8'd11,  prod: 16'h008F, hold: 1};
      vecs[1] = '{a: 8'd255, b: 8'd255, prod: 16'hFE01, hold: 5};
      vecs[2] = '{a: 8'd0,   b: 8'd200, prod: 16'h0000, hold: 0};
      vecs[3] = '{a: 8'd200, b: 8'd0,   prod: 16'h0000, hold: 2};
      vecs[4] = '{a: 8'd77,  b: 8'd1,   prod: 16'd77,   hold: 0};
      vecs[5] = '{a: 8'd1,   b: 8'h10,  prod: 16'h0010, hold: 1};
      vecs[6] = '{a: 8'd3,   b: 8'h80,  prod: 16'h0180, hold: 3};
      vecs[7] = '{a: 8'd100, b: 8'd3,   prod: 16'd300,  hold: 0};
      vecs[8] = '{a: 8'd171, b: 8'd205, prod: 16'd35055, hold: 1};

      arst_n = 1'b0;
      a = '0;
      b = '0;
      in_valid = 1'b0;
      ds_ready = 1'b0;
      #12;
      chk("rst_ready", 32'(rdy), 32'd1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_product", 32'(product), 32'd0);
      @(negedge clk);
      arst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset on the 4th RUN cycle of 100*3 discards the partial result.
      @(negedge clk);
      a = 8'd100;
      b = 8'd3;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_reset_acc_nonzero", 32'(product != 0), 32'd1);
      #1 arst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_ready", 32'(rdy), 32'd1);
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_product", 32'(product), 32'd0);
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      repeat (W + 2) begin
         @(negedge clk);
         chk("no_valid_after_rst", 32'(out_valid), 32'd0);
      end
      chk("rst_idle_product", 32'(product), 32'd0);
      run_vec('{a: 8'd7, b: 8'd9, prod: 16'h003F, hold: 2});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
